// File: rtl/ppu_pkg.sv
// Shared types and address-map constants for the PPU memory-port arbiter.
package ppu_pkg;

    typedef enum logic {
        TGT_VRAM = 1'b0,
        TGT_PAL  = 1'b1
    } mem_tgt_t;

    typedef enum logic {
        OWN_RENDER = 1'b0,
        OWN_CPU    = 1'b1
    } owner_t;

    localparam logic [13:0] PAT_END  = 14'h1FFF;
    localparam logic [13:0] NT_BASE  = 14'h2000;
    localparam logic [13:0] PAL_BASE = 14'h3F00;

endpackage

// File: rtl/ppu_addr_mirror.sv
// PPU address decode: selects VRAM or palette_mem and folds the mirrored
// nametable and palette regions onto their canonical locations.
module ppu_addr_mirror
    import ppu_pkg::*;
(
    input  logic [13:0] a,
    input  logic        mirror_vertical,
    output logic        tgt,
    output logic [15:0] VRAM_addr,
    output logic [4:0]  palette_addr
);

    // Horizontal mirroring keeps a[11] as the table select, vertical keeps a[10];
    // a[12] is dropped so 0x3xxx aliases 0x2xxx.
    always_comb begin
        tgt          = TGT_VRAM;
        VRAM_addr    = {2'b00, a};
        palette_addr = a[4:0];
        if (a[1:0] == 2'b00) begin
            palette_addr[4] = 1'b0;
        end
        if (a <= PAT_END) begin
            tgt       = TGT_VRAM;
            VRAM_addr = {2'b00, a};
        end else if (a >= PAL_BASE) begin
            tgt       = TGT_PAL;
            VRAM_addr = {2'b00, a};
        end else begin
            tgt       = TGT_VRAM;
            VRAM_addr = {2'b00, NT_BASE}
                      | (mirror_vertical ? {5'b0, a[10], 10'b0} : {4'b0, a[11], 11'b0})
                      | {6'b0, a[9:0]};
        end
    end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Owns the PPU memory port: arbitrates render fetches against CPU PPUDATA
// accesses and routes one-cycle-latency read data back to the issuer.
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        render_active,
    input  logic        mirror_vertical,
    input  logic        render_req,
    input  logic [13:0] render_addr,
    output logic        render_gnt,
    output logic        render_rvalid,
    output logic [7:0]  render_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] VRAM_addr,
    output logic        VRAM_WE,
    output logic [7:0]  VRAM_data_in,
    input  logic [7:0]  VRAM_data_out,
    output logic [4:0]  palette_addr,
    output logic        palette_WE,
    output logic [7:0]  palette_data_in,
    input  logic [7:0]  palette_out
);

    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    owner_t            rr_ptr;
    logic              rd_pending;
    owner_t            rd_owner;
    mem_tgt_t          rd_tgt;
    logic [15:0]       last_vram_addr;
    logic [4:0]        last_palette_addr;
    logic [7:0]        cpu_hold;
    logic [7:0]        render_hold;

    logic              grant_cpu;
    logic              grant_render;
    logic              any_gnt;
    logic              wait_full;
    logic              read_issue;
    logic [13:0]       gnt_addr;
    logic              mir_tgt;
    logic [15:0]       mir_vram_addr;
    logic [4:0]        mir_palette_addr;
    logic [7:0]        ret_data;
    logic              unused_palette_bits;

    assign wait_full = (wait_cnt == WAIT_W'(CPU_MAX_WAIT));

    // Render owns the port while drawing unless the CPU has starved long enough;
    // otherwise the pointer breaks ties between simultaneous requests.
    always_comb begin
        grant_cpu    = 1'b0;
        grant_render = 1'b0;
        if (!reset) begin
            if (render_active) begin
                if (cpu_req && (!render_req || wait_full)) begin
                    grant_cpu = 1'b1;
                end else if (render_req) begin
                    grant_render = 1'b1;
                end
            end else begin
                if (cpu_req && (!render_req || rr_ptr == OWN_CPU)) begin
                    grant_cpu = 1'b1;
                end else if (render_req) begin
                    grant_render = 1'b1;
                end
            end
        end
    end

    assign any_gnt    = grant_cpu | grant_render;
    assign read_issue = grant_render | (grant_cpu & ~cpu_we);
    assign gnt_addr   = grant_cpu ? cpu_addr : render_addr;

    ppu_addr_mirror u_mirror (
        .a               (gnt_addr),
        .mirror_vertical (mirror_vertical),
        .tgt             (mir_tgt),
        .VRAM_addr       (mir_vram_addr),
        .palette_addr    (mir_palette_addr)
    );

    assign render_gnt      = grant_render;
    assign cpu_gnt         = grant_cpu;
    assign VRAM_addr       = any_gnt ? mir_vram_addr : last_vram_addr;
    assign palette_addr    = any_gnt ? mir_palette_addr : last_palette_addr;
    assign VRAM_WE         = grant_cpu & cpu_we & (mir_tgt == TGT_VRAM);
    assign palette_WE      = grant_cpu & cpu_we & (mir_tgt == TGT_PAL);
    assign VRAM_data_in    = cpu_wdata;
    assign palette_data_in = cpu_wdata;

    // The palette RAM is only 6 bits wide in practice.
    assign ret_data = (rd_tgt == TGT_PAL) ? {2'b00, palette_out[5:0]} : VRAM_data_out;
    assign unused_palette_bits = &{1'b0, palette_out[7:6]};

    assign cpu_rvalid    = ~reset & rd_pending & (rd_owner == OWN_CPU);
    assign render_rvalid = ~reset & rd_pending & (rd_owner == OWN_RENDER);
    assign cpu_rdata     = reset ? 8'h00 : (cpu_rvalid ? ret_data : cpu_hold);
    assign render_rdata  = reset ? 8'h00 : (render_rvalid ? ret_data : render_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt          <= '0;
            rr_ptr            <= OWN_CPU;
            rd_pending        <= 1'b0;
            rd_owner          <= OWN_CPU;
            rd_tgt            <= TGT_VRAM;
            last_vram_addr    <= 16'h0000;
            last_palette_addr <= 5'h00;
            cpu_hold          <= 8'h00;
            render_hold       <= 8'h00;
        end else begin
            if (grant_cpu) begin
                wait_cnt <= '0;
            end else if (cpu_req && !wait_full) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (grant_cpu) begin
                rr_ptr <= OWN_RENDER;
            end else if (grant_render) begin
                rr_ptr <= OWN_CPU;
            end
            rd_pending <= read_issue;
            rd_owner   <= grant_cpu ? OWN_CPU : OWN_RENDER;
            rd_tgt     <= mem_tgt_t'(mir_tgt);
            if (any_gnt) begin
                last_vram_addr    <= mir_vram_addr;
                last_palette_addr <= mir_palette_addr;
            end
            if (cpu_rvalid) begin
                cpu_hold <= ret_data;
            end
            if (render_rvalid) begin
                render_hold <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Self-checking bench for ppu_vram_arbiter with behavioural VRAM/palette models
// and a scoreboard of expected read returns.
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        render_active = 1'b0;
    logic        mirror_vertical = 1'b0;
    logic        render_req = 1'b0;
    logic [13:0] render_addr = 14'h0;
    logic        render_gnt, render_rvalid;
    logic [7:0]  render_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = 14'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [15:0] VRAM_addr;
    logic        VRAM_WE;
    logic [7:0]  VRAM_data_in;
    logic [7:0]  VRAM_data_out = 8'h0;
    logic [4:0]  palette_addr;
    logic        palette_WE;
    logic [7:0]  palette_data_in;
    logic [7:0]  palette_out = 8'h0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic       own_cpu;
        logic [7:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    logic [7:0] vram_mem  [0:16383];
    bit         vram_valid[0:16383];
    logic [7:0] pal_mem   [0:31];
    bit         pal_valid [0:31];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppu_vram_arbiter #(.CPU_MAX_WAIT(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .render_active   (render_active),
        .mirror_vertical (mirror_vertical),
        .render_req      (render_req),
        .render_addr     (render_addr),
        .render_gnt      (render_gnt),
        .render_rvalid   (render_rvalid),
        .render_rdata    (render_rdata),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_gnt         (cpu_gnt),
        .cpu_rvalid      (cpu_rvalid),
        .cpu_rdata       (cpu_rdata),
        .VRAM_addr       (VRAM_addr),
        .VRAM_WE         (VRAM_WE),
        .VRAM_data_in    (VRAM_data_in),
        .VRAM_data_out   (VRAM_data_out),
        .palette_addr    (palette_addr),
        .palette_WE      (palette_WE),
        .palette_data_in (palette_data_in),
        .palette_out     (palette_out)
    );

    function automatic logic [7:0] vram_fill(input logic [13:0] i);
        return i[7:0] ^ {i[13:8], 2'b01};
    endfunction

    function automatic logic [7:0] vram_word(input logic [13:0] i);
        return vram_valid[i] ? vram_mem[i] : vram_fill(i);
    endfunction

    function automatic logic [7:0] pal_word(input logic [4:0] i);
        return pal_valid[i] ? pal_mem[i] : {3'b110, i};
    endfunction

    // Synchronous memories: data appears the cycle after the address.
    always @(posedge clk) begin
        if (VRAM_WE) begin
            vram_mem[VRAM_addr[13:0]]   <= VRAM_data_in;
            vram_valid[VRAM_addr[13:0]] <= 1'b1;
        end
        if (palette_WE) begin
            pal_mem[palette_addr]   <= palette_data_in;
            pal_valid[palette_addr] <= 1'b1;
        end
        VRAM_data_out <= vram_word(VRAM_addr[13:0]);
        palette_out   <= pal_word(palette_addr);
    end

    function automatic logic [7:0] model_read(input logic [13:0] a, input logic mv);
        logic [4:0]  idx;
        logic [13:0] phys;
        if (a[13:8] == 6'h3F) begin
            idx = a[4:0];
            if (idx[1:0] == 2'b00) idx[4] = 1'b0;
            phys = {9'b0, idx};
            return {2'b00, pal_word(phys[4:0]) & 8'h3F};
        end
        if (a < 14'h2000) begin
            phys = a;
        end else begin
            phys = a & 14'h0FFF;
            if (mv) phys[11] = 1'b0;
            else    phys[10] = 1'b0;
            phys = phys | 14'h2000;
        end
        return vram_word(phys);
    endfunction

    task automatic applyStimulus(input logic mv, input logic c_req, input logic c_we,
                                 input logic [13:0] c_addr, input logic [7:0] c_wdata,
                                 input logic r_req, input logic [13:0] r_addr);
        @(negedge clk);
        mirror_vertical = mv;
        cpu_req         = c_req;
        cpu_we          = c_we;
        cpu_addr        = c_addr;
        cpu_wdata       = c_wdata;
        render_req      = r_req;
        render_addr     = r_addr;
        #1;
    endtask

    task automatic expectRead(input logic own_cpu, input logic [13:0] a);
        rd_exp_t e;
        e.due     = cyc + 1;
        e.own_cpu = own_cpu;
        e.data    = model_read(a, mirror_vertical);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns are compared every cycle against the scoreboard head.
    task automatic monitor_returns();
        rd_exp_t    e;
        logic       exp_cv, exp_rv;
        logic [7:0] exp_d;
        forever begin
            @(negedge clk);
            #2;
            exp_cv = 1'b0;
            exp_rv = 1'b0;
            exp_d  = 8'h00;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due == cyc) begin
                    exp_cv = e.own_cpu;
                    exp_rv = !e.own_cpu;
                    exp_d  = e.data;
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stale_return due=%0d now=%0d", e.due, cyc);
                end
            end
            if (cpu_rvalid || exp_cv) begin
                checks++;
                if (cpu_rvalid !== exp_cv || (exp_cv && cpu_rdata !== exp_d)) begin
                    errors++;
                    $display("[TB] FAIL cpu_return cyc=%0d got rvalid=%b data=%h expected rvalid=%b data=%h",
                             cyc, cpu_rvalid, cpu_rdata, exp_cv, exp_d);
                end
            end
            if (render_rvalid || exp_rv) begin
                checks++;
                if (render_rvalid !== exp_rv || (exp_rv && render_rdata !== exp_d)) begin
                    errors++;
                    $display("[TB] FAIL render_return cyc=%0d got rvalid=%b data=%h expected rvalid=%b data=%h",
                             cyc, render_rvalid, render_rdata, exp_rv, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 14'h0200, 8'h0, 1'b1, 14'h0100);
        @(negedge clk);
        #1;
        checks++;
        if ({render_gnt, cpu_gnt} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_gnt got=%b expected=00", {render_gnt, cpu_gnt});
        end
        checks++;
        if ({render_rvalid, cpu_rvalid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_rvalid got=%b expected=00", {render_rvalid, cpu_rvalid});
        end
        checks++;
        if ({VRAM_WE, palette_WE} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_we got=%b expected=00", {VRAM_WE, palette_WE});
        end
        checks++;
        if (cpu_rdata !== 8'h00 || render_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_rdata got cpu=%h render=%h expected 00", cpu_rdata, render_rdata);
        end
        do_reset();
    endtask

    task automatic test_priority();
        logic exp_cpu;
        logic [13:0] ra;
        do_reset();
        render_active = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            ra = 14'h0100 + 14'(k);
            applyStimulus(1'b0, 1'b1, 1'b0, 14'h0200, 8'h0, 1'b1, ra);
            exp_cpu = (k == 9);
            checks++;
            if (cpu_gnt !== exp_cpu || render_gnt !== !exp_cpu) begin
                errors++;
                $display("[TB] FAIL priority_gnt cycle=%0d got cpu=%b render=%b expected cpu=%b render=%b",
                         k, cpu_gnt, render_gnt, exp_cpu, !exp_cpu);
            end
            expectRead(exp_cpu, exp_cpu ? 14'h0200 : ra);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        render_active = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_cpu;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 14'h0300 + 14'(k), 8'h0, 1'b1, 14'h0080 + 14'(k));
            exp_cpu = (k % 2 == 0);
            checks++;
            if (cpu_gnt !== exp_cpu || render_gnt !== !exp_cpu) begin
                errors++;
                $display("[TB] FAIL rr_gnt step=%0d got cpu=%b render=%b expected cpu=%b render=%b",
                         k, cpu_gnt, render_gnt, exp_cpu, !exp_cpu);
            end
            expectRead(exp_cpu, exp_cpu ? 14'h0300 + 14'(k) : 14'h0080 + 14'(k));
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b1, 14'h0040 + 14'(k));
            checks++;
            if (render_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_single_render step=%0d got render=%b cpu=%b expected 1 0",
                         k, render_gnt, cpu_gnt);
            end
            expectRead(1'b0, 14'h0040 + 14'(k));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
    endtask

    task automatic test_mirror();
        logic [13:0] wa[4];
        logic        wmv[4];
        logic [7:0]  wd[4];
        logic [15:0] ea[4];
        wa  = '{14'h2C05, 14'h2C05, 14'h3005, 14'h1234};
        wmv = '{1'b0, 1'b1, 1'b0, 1'b0};
        wd  = '{8'h55, 8'h66, 8'h77, 8'h88};
        ea  = '{16'h2805, 16'h2405, 16'h2005, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(wmv[i], 1'b1, 1'b1, wa[i], wd[i], 1'b0, 14'h0);
            checks++;
            if ({cpu_gnt, VRAM_WE, palette_WE} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL write_strobe addr=%h got gnt/vwe/pwe=%b expected 110",
                         wa[i], {cpu_gnt, VRAM_WE, palette_WE});
            end
            checks++;
            if (VRAM_addr !== ea[i] || VRAM_data_in !== wd[i]) begin
                errors++;
                $display("[TB] FAIL mirror_addr addr=%h mv=%b got %h/%h expected %h/%h",
                         wa[i], wmv[i], VRAM_addr, VRAM_data_in, ea[i], wd[i]);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        checks++;
        if (VRAM_addr !== 16'h1234 || {VRAM_WE, palette_WE} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_hold got addr=%h we=%b expected addr=1234 we=00",
                     VRAM_addr, {VRAM_WE, palette_WE});
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(wmv[i], 1'b1, 1'b0, wa[i], 8'h0, 1'b0, 14'h0);
            checks++;
            if (cpu_gnt !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mirror_read_gnt addr=%h got %b expected 1", wa[i], cpu_gnt);
            end
            expectRead(1'b1, wa[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
    endtask

    task automatic test_palette();
        applyStimulus(1'b0, 1'b1, 1'b1, 14'h3F10, 8'h3F, 1'b0, 14'h0);
        checks++;
        if (palette_addr !== 5'h00 || palette_data_in !== 8'h3F) begin
            errors++;
            $display("[TB] FAIL pal_write_addr got idx=%h data=%h expected 00/3f", palette_addr, palette_data_in);
        end
        checks++;
        if ({palette_WE, VRAM_WE} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL pal_write_we got pwe/vwe=%b expected 10", {palette_WE, VRAM_WE});
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 14'h3F05, 8'hC5, 1'b0, 14'h0);
        checks++;
        if (palette_addr !== 5'h05 || palette_WE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pal_write2 got idx=%h we=%b expected 05/1", palette_addr, palette_WE);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 14'h3F00, 8'h0, 1'b0, 14'h0);
        expectRead(1'b1, 14'h3F00);
        applyStimulus(1'b0, 1'b1, 1'b0, 14'h3F05, 8'h0, 1'b0, 14'h0);
        expectRead(1'b1, 14'h3F05);
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b1, 14'h3F14);
        checks++;
        if (render_gnt !== 1'b1 || palette_addr !== 5'h04) begin
            errors++;
            $display("[TB] FAIL pal_render_read got gnt=%b idx=%h expected 1/04", render_gnt, palette_addr);
        end
        expectRead(1'b0, 14'h3F14);
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        checks++;
        if (cpu_rdata !== 8'h05 || render_rdata !== 8'h04) begin
            errors++;
            $display("[TB] FAIL rdata_hold got cpu=%h render=%h expected 05/04", cpu_rdata, render_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        applyStimulus(1'b0, 1'b1, 1'b0, 14'h0200, 8'h0, 1'b0, 14'h0);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midread_gnt got %b expected 1", cpu_gnt);
        end
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || render_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midread_drop got rvalid=%b cpu=%h render=%h expected 0/00/00",
                     cpu_rvalid, cpu_rdata, render_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || {VRAM_WE, palette_WE} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_reset got rvalid=%b rdata=%h we=%b expected 0/00/00",
                     cpu_rvalid, cpu_rdata, {VRAM_WE, palette_WE});
        end
    endtask

    initial begin
        fork
            monitor_returns();
        join_none
        test_reset();
        test_priority();
        test_round_robin();
        test_mirror();
        test_palette();
        test_reset_mid_read();
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 14'h0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
